// File: rtl/uart_receiver.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : uart_receiver
// Description : 8N1 UART receiver, LSB first, idle-high line. The line passes
//               through a two-flop synchronizer. Each bit is sampled at
//               mid-bit by a small FSM. Each received frame produces a
//               one-cycle valid or frame_err pulse.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module uart_receiver #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int W = $clog2(CLKS_PER_BIT);

    // Half-bit point inside the start bit, and the full-bit point used for
    // the data and stop bits.
    localparam logic [W-1:0] c_HALF_LAST = W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [W-1:0] c_BIT_LAST  = W'(CLKS_PER_BIT - 1);
    localparam logic [W-1:0] c_CNT_ONE   = W'(1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_START = 3'd1;
    localparam logic [2:0] c_ST_DATA  = 3'd2;
    localparam logic [2:0] c_ST_STOP  = 3'd3;
    localparam logic [2:0] c_ST_BREAK = 3'd4;

    logic         r_sync1;
    logic         r_rx_s;
    logic [2:0]   r_state;
    logic [W-1:0] r_cnt;
    logic [2:0]   r_bit_idx;
    logic [7:0]   r_shift;
    logic [7:0]   r_data;
    logic         r_valid;
    logic         r_frame_err;
    logic         r_busy;

    logic [2:0]   w_state_nxt;
    logic [W-1:0] w_cnt_nxt;
    logic [2:0]   w_bit_nxt;
    logic [7:0]   w_shift_nxt;
    logic [7:0]   w_data_nxt;
    logic         w_valid_nxt;
    logic         w_frame_err_nxt;

    // Two-flop synchronizer; both flops reset to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_rx_s  <= r_sync1;
        end
    end

    // State and datapath registers; busy lags the state by one cycle so it
    // stays high through the cycle that carries the valid pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_idx   <= w_bit_nxt;
            r_shift     <= w_shift_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_busy      <= (r_state != c_ST_IDLE);
        end
    end

    // Next-state and datapath decode; everything holds unless a state acts.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_bit_nxt       = r_bit_idx;
        w_shift_nxt     = r_shift;
        w_data_nxt      = r_data;
        w_valid_nxt     = 1'b0;
        w_frame_err_nxt = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                // Level detect, so a start bit right after STOP is caught.
                if (!r_rx_s) begin
                    w_state_nxt = c_ST_START;
                    w_cnt_nxt   = '0;
                end
            end

            c_ST_START: begin
                if (r_cnt == c_HALF_LAST) begin
                    w_cnt_nxt = '0;
                    if (!r_rx_s) begin
                        w_state_nxt = c_ST_DATA;
                        w_bit_nxt   = 3'd0;
                    end else begin
                        // Line went back high before mid start bit: glitch.
                        w_state_nxt = c_ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end

            c_ST_DATA: begin
                if (r_cnt == c_BIT_LAST) begin
                    w_cnt_nxt              = '0;
                    w_shift_nxt[r_bit_idx] = r_rx_s;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = c_ST_STOP;
                    end else begin
                        w_bit_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end

            c_ST_STOP: begin
                if (r_cnt == c_BIT_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_rx_s) begin
                        w_data_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = c_ST_IDLE;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = c_ST_BREAK;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end

            c_ST_BREAK: begin
                // Wait out a held-low line so it is not taken as a new start.
                if (r_rx_s) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_uart_receiver
// Description : Directed self-checking bench for uart_receiver at 16 clk/bit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_uart_receiver;

    localparam int c_CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int         n_valid = 0;
    int         n_ferr  = 0;
    int         n_both  = 0;
    logic [7:0] vdata[$];
    int         vcyc[$];
    logic       busy_at_v    = 1'b0;
    logic       busy_after_v = 1'b1;
    logic       prev_v       = 1'b0;

    uart_receiver #(.CLKS_PER_BIT(c_CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: records every valid/frame_err cycle away from the edge.
    always @(negedge clk) begin
        if (valid) begin
            n_valid++;
            vdata.push_back(data);
            vcyc.push_back(cyc);
            busy_at_v = busy;
        end
        if (prev_v) busy_after_v = busy;
        prev_v = valid;
        if (frame_err) n_ferr++;
        if (valid && frame_err) n_both++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stopv);
        send_bit(1'b0, c_CPB);
        for (int i = 0; i < 8; i++) send_bit(b[i], c_CPB);
        send_bit(stopv, c_CPB);
    endtask

    int t_start;
    int lat;
    int nv0;
    int nf0;
    int off[10];

    initial begin
        // ---- reset ----
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_data",  {24'h0, data}, 32'h00);
        check("rst_valid", {31'h0, valid}, 32'h0);
        check("rst_ferr",  {31'h0, frame_err}, 32'h0);
        check("rst_busy",  {31'h0, busy}, 32'h0);
        repeat (5) @(negedge clk);

        // ---- single frame 0xA5 ----
        t_start = cyc;
        send_frame(8'hA5, 1'b1);
        repeat (4) @(negedge clk);
        check("a5_nvalid", n_valid, 1);
        check("a5_data",   {24'h0, vdata[0]}, 32'hA5);
        check("a5_ferr",   n_ferr, 0);
        check("a5_busy_at_valid", {31'h0, busy_at_v}, 32'h1);
        check("a5_busy_after",    {31'h0, busy_after_v}, 32'h0);
        // Latency counted from the first cycle rx_s is low (two sync flops
        // after the drive); nominal 8 + 9*16 = 152, +-1 allowed.
        lat = vcyc[0] - (t_start + 2);
        check("a5_latency_window", {31'h0, (lat >= 151 && lat <= 153)}, 32'h1);
        repeat (10) @(negedge clk);

        // ---- back-to-back 0x00 then 0xFF ----
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (4) @(negedge clk);
        check("b2b_nvalid", n_valid, 3);
        check("b2b_data0",  {24'h0, vdata[1]}, 32'h00);
        check("b2b_data1",  {24'h0, vdata[2]}, 32'hFF);
        check("b2b_spacing_window",
              {31'h0, ((vcyc[2] - vcyc[1]) >= 159 && (vcyc[2] - vcyc[1]) <= 161)}, 32'h1);
        repeat (10) @(negedge clk);

        // ---- 4-cycle glitch, then 0x3C ----
        send_bit(1'b0, 4);
        send_bit(1'b1, 12);
        check("glitch_busy",   {31'h0, busy}, 32'h0);
        check("glitch_nvalid", n_valid, 3);
        check("glitch_nferr",  n_ferr, 0);
        send_frame(8'h3C, 1'b1);
        repeat (4) @(negedge clk);
        check("g3c_nvalid", n_valid, 4);
        check("g3c_data",   {24'h0, data}, 32'h3C);
        repeat (10) @(negedge clk);

        // ---- 0x5A with stop bit low, line held low 40 cycles ----
        send_frame(8'h5A, 1'b0);
        send_bit(1'b0, 40);
        check("brk_busy_low_line", {31'h0, busy}, 32'h1);
        check("brk_nferr",  n_ferr, 1);
        check("brk_nvalid", n_valid, 4);
        check("brk_data_kept", {24'h0, data}, 32'h3C);
        send_bit(1'b1, 10);
        check("brk_busy_released", {31'h0, busy}, 32'h0);
        send_bit(1'b1, 20);
        check("brk_no_new_frame", {31'h0, busy}, 32'h0);
        check("brk_nvalid_after", n_valid, 4);

        // ---- reset during data bit 3, then 0x81 ----
        nv0 = n_valid;
        nf0 = n_ferr;
        send_bit(1'b0, c_CPB);
        send_bit(1'b0, c_CPB);
        send_bit(1'b1, c_CPB);
        send_bit(1'b1, c_CPB);
        send_bit(1'b0, 8);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_data",  {24'h0, data}, 32'h00);
        check("mrst_busy",  {31'h0, busy}, 32'h0);
        check("mrst_valid", {31'h0, valid}, 32'h0);
        check("mrst_ferr",  {31'h0, frame_err}, 32'h0);
        rst = 1'b0;
        send_bit(1'b1, 40);
        check("mrst_no_pulse", n_valid + n_ferr, nv0 + nf0);
        send_frame(8'h81, 1'b1);
        repeat (4) @(negedge clk);
        check("m81_nvalid", n_valid, nv0 + 1);
        check("m81_data",   {24'h0, data}, 32'h81);
        repeat (10) @(negedge clk);

        // ---- 0xC3 with bit edges jittered by up to +-3 cycles ----
        off = '{0, 3, -3, 2, -3, 3, -1, -3, 3, 0};
        nv0 = n_valid;
        send_bit(1'b0, c_CPB + off[1] - off[0]);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] b;
            b = 8'hC3;
            send_bit(b[i], c_CPB + off[i + 2] - off[i + 1]);
        end
        send_bit(1'b1, c_CPB + 4);
        check("jit_nvalid", n_valid, nv0 + 1);
        check("jit_data",   {24'h0, data}, 32'hC3);

        // ---- global properties ----
        check("never_both", n_both, 0);
        check("total_ferr", n_ferr, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
